// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared definitions for the byte-stream IMEM program loader:
//               default IMEM geometry, loader state encoding and a helper
//               that classifies the states in which a load is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Default IMEM geometry
    localparam int unsigned c_IMEM_ADDR_WIDTH = 32;
    localparam int unsigned c_IMEM_WIDTH      = 8;
    localparam int unsigned c_IMEM_DEPTH      = 256;
    localparam int unsigned c_BASE_ADDR       = 0;

    // Loader state encoding
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LEN_HI = 3'd1;
    localparam state_t S_LEN_LO = 3'd2;
    localparam state_t S_LOAD   = 3'd3;
    localparam state_t S_CHECK  = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_ERROR  = 3'd6;

    // A load is in flight in every state that consumes stream bytes.
    function automatic logic is_loading(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_LOAD) || (s == S_CHECK);
    endfunction

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader. Accepts a big-endian 16-bit
//               length followed by that many payload bytes over valid/ready
//               and writes each payload byte to successive IMEM byte
//               addresses starting at BASE_ADDR. Holds the core stalled
//               (cpu_hold) while a load is in flight.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN - a trailing
//               XOR checksum byte is accepted and compared after the payload.
// Ports       : clk, rst (sync, active-high), start,
//               in_data/in_valid/in_ready  - host byte stream
//               mem_we/mem_addr/mem_wdata  - registered IMEM write port
//               busy, done, error, cpu_hold - status (levels)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_WIDTH = c_IMEM_ADDR_WIDTH,
    parameter int unsigned IMEM_WIDTH      = c_IMEM_WIDTH,
    parameter int unsigned IMEM_DEPTH      = c_IMEM_DEPTH,
    parameter int unsigned BASE_ADDR       = c_BASE_ADDR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       mem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]                 mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       cpu_hold
);

    // The loader writes one byte per IMEM cell; any other cell width is a
    // configuration error.
    generate
        if (IMEM_WIDTH != 8) begin : g_bad_width
            $error("imem_loader: IMEM_WIDTH must be 8");
        end
    endgenerate

    // One extra bit so BASE_ADDR + len cannot wrap in the bound check.
    localparam int unsigned ADDR_W1 = IMEM_ADDR_WIDTH + 1;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [15:0]                r_len;
    logic [15:0]                r_cnt;
    logic                       r_mem_we;
    logic [IMEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]                 r_mem_wdata;

    logic                       w_accept;
    logic [15:0]                w_len_full;
    logic [ADDR_W1-1:0]         w_end;
    logic                       w_fits;
    logic                       w_last;
    logic [IMEM_ADDR_WIDTH-1:0] w_addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 r_csum;
`endif

    // in_ready is a function of state only, so no comb path from in_valid.
    assign in_ready   = is_loading(r_state);
    assign busy       = is_loading(r_state);
    assign cpu_hold   = is_loading(r_state);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERROR);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    assign w_accept   = in_valid && in_ready;
    // Full length as it will be once the low byte on in_data is taken.
    assign w_len_full = {r_len[15:8], in_data};
    assign w_end      = ADDR_W1'(BASE_ADDR) + ADDR_W1'(w_len_full);
    assign w_fits     = (w_end <= ADDR_W1'(IMEM_DEPTH));
    // This accept completes the payload.
    assign w_last     = (({1'b0, r_cnt} + 17'd1) == {1'b0, r_len});
    assign w_addr     = IMEM_ADDR_WIDTH'(BASE_ADDR) + IMEM_ADDR_WIDTH'(r_cnt);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else if (!w_fits) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept && w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    w_state_nxt = (in_data == r_csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and write datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= 16'd0;
            r_cnt       <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= IMEM_ADDR_WIDTH'(BASE_ADDR);
            r_mem_wdata <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: r_len[15:8] <= in_data;
                    S_LEN_LO: begin
                        r_len[7:0] <= in_data;
                        r_cnt      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                    S_LOAD: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= in_data;
                        r_cnt       <= r_cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum      <= r_csum ^ in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected IMEM writes are
//               queued as stimulus is driven and checked by a write monitor;
//               status outputs are checked at directed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int          n_vec;
    int          n_err;
    wr_t         exp_q[$];
    logic [7:0]  model_mem [256];

    imem_loader #(
        .IMEM_ADDR_WIDTH(32),
        .IMEM_WIDTH     (8),
        .IMEM_DEPTH     (256),
        .BASE_ADDR      (0)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", mem_addr, mem_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", mem_addr, e.addr);
                chk("write_data", {24'd0, mem_wdata}, {24'd0, e.data});
            end
            model_mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout observed=in_ready_low expected=accept");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    endtask

    logic [7:0] pay [4];

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        clear_model();
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_error",    {31'd0, error},    32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_mem_addr", mem_addr,          32'd0);
        chk("rst_mem_wdata",{24'd0, mem_wdata},32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: back-to-back load of DE AD BE EF
        pulse_start();
        @(negedge clk);
        chk("t1_busy_len", {31'd0, busy}, 32'd1);
        chk("t1_hold_len", {31'd0, cpu_hold}, 32'd1);
        tick();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'(i), pay[i]);
            send_byte(pay[i]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("t1_busy_check", {31'd0, busy}, 32'd1);
        tick();
        send_byte(8'h22);
`endif
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (2) tick();
        chk("t1_word0", {model_mem[0], model_mem[1], model_mem[2], model_mem[3]}, 32'hDEADBEEF);
        chk("t1_pending", 32'(exp_q.size()), 32'd0);

        // 2: same stream with gaps, restarting from DONE
        clear_model();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'(i), pay[i]);
            send_byte(pay[i]);
            if (i < 3) begin
                @(negedge clk);
                chk("t2_ready_gap", {31'd0, in_ready}, 32'd1);
                tick();
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h22);
`endif
        @(negedge clk);
        chk("t2_done", {31'd0, done}, 32'd1);
        repeat (2) tick();
        chk("t2_word0", {model_mem[0], model_mem[1], model_mem[2], model_mem[3]}, 32'hDEADBEEF);

        // 3: length 257 exceeds IMEM depth
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_done",  {31'd0, done},  32'd0);
        chk("t3_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_busy",  {31'd0, busy},  32'd0);
        repeat (3) tick();
        chk("t3_error_hold", {31'd0, error}, 32'd1);

        // 4: zero length, then restart from DONE
        pulse_start();
        @(negedge clk);
        chk("t4_error_clr", {31'd0, error}, 32'd0);
        tick();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        @(negedge clk);
        chk("t4_done", {31'd0, done}, 32'd1);
        tick();
        start = 1'b1;
        @(negedge clk);
        chk("t4_done_before", {31'd0, done}, 32'd1);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t4_done_cleared", {31'd0, done}, 32'd0);
        chk("t4_busy_again",   {31'd0, busy}, 32'd1);
        chk("t4_ready_again",  {31'd0, in_ready}, 32'd1);
        tick();

        // 5: reset after the 2nd of 4 payload bytes
        clear_model();
        send_byte(8'h00);
        send_byte(8'h04);
        expect_wr(32'd0, 8'hDE);
        send_byte(8'hDE);
        expect_wr(32'd1, 8'hAD);
        send_byte(8'hAD);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_mem_we",   {31'd0, mem_we},   32'd0);
        chk("t5_busy",     {31'd0, busy},     32'd0);
        chk("t5_ready",    {31'd0, in_ready}, 32'd0);
        chk("t5_done",     {31'd0, done},     32'd0);
        chk("t5_error",    {31'd0, error},    32'd0);
        chk("t5_hold",     {31'd0, cpu_hold}, 32'd0);
        chk("t5_mem_addr", mem_addr,          32'd0);
        chk("t5_wdata",    {24'd0, mem_wdata},32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_mem_lo", {model_mem[0], model_mem[1], model_mem[2], model_mem[3]}, 32'hDEAD0000);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        expect_wr(32'd0, 8'h12);
        send_byte(8'h12);
        expect_wr(32'd1, 8'h34);
        send_byte(8'h34);
        send_byte(8'h26);
        @(negedge clk);
        chk("t6_done_ok", {31'd0, done}, 32'd1);
        tick();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        expect_wr(32'd0, 8'h12);
        send_byte(8'h12);
        expect_wr(32'd1, 8'h34);
        send_byte(8'h34);
        send_byte(8'h27);
        @(negedge clk);
        chk("t6_error_bad", {31'd0, error}, 32'd1);
        tick();
`endif

        repeat (3) tick();
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
